// File: rtl/cci_host_mem_responder.sv
// cci_host_mem_responder: loopback host memory answering ch0 line reads and ch1 write acks after a fixed minimum latency.
// Define CCI_HOST_MEM_RANGE_CHK_EN to flag out-of-range addresses (reads return zero, writes skip the array).
module cci_host_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int CL_ADDR_W   = 42,
    parameter int DATA_W      = 512,
    parameter int MDATA_W     = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int ALM_FULL_TH = 2,
    parameter int RD_LATENCY  = 4,
    parameter int WR_LATENCY  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_req_en,
    input  logic [CL_ADDR_W-1:0] rd_req_addr,
    input  logic [MDATA_W-1:0]   rd_req_mdata,
    input  logic                 wr_req_en,
    input  logic [CL_ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0]    wr_req_data,
    input  logic [MDATA_W-1:0]   wr_req_mdata,
    output logic                 c0_alm_full,
    output logic                 c1_alm_full,
    output logic                 rd_rsp_valid,
    output logic [DATA_W-1:0]    rd_rsp_data,
    output logic [MDATA_W-1:0]   rd_rsp_mdata,
    output logic                 wr_rsp_valid,
    output logic [MDATA_W-1:0]   wr_rsp_mdata,
    output logic                 err_overflow,
    output logic                 err_range
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = PW + 1;

    logic [DATA_W-1:0]  mem [2**ADDR_W];
    logic [7:0]         stamp;

    logic [ADDR_W-1:0]  rq_idx [FIFO_DEPTH];
    logic [MDATA_W-1:0] rq_md  [FIFO_DEPTH];
    logic [7:0]         rq_st  [FIFO_DEPTH];
    logic               rq_oor [FIFO_DEPTH];
    logic [PW-1:0]      rq_wp, rq_rp;
    logic [OW-1:0]      rq_occ, rq_occ_nxt;

    logic [MDATA_W-1:0] wq_md [FIFO_DEPTH];
    logic [7:0]         wq_st [FIFO_DEPTH];
    logic [PW-1:0]      wq_wp, wq_rp;
    logic [OW-1:0]      wq_occ, wq_occ_nxt;

    logic rd_full, rd_pop, rd_push, wr_full, wr_pop, wr_push;
    logic rd_oor, wr_oor;
    logic [7:0] rd_age, wr_age;

`ifdef CCI_HOST_MEM_RANGE_CHK_EN
    assign rd_oor = |rd_req_addr[CL_ADDR_W-1:ADDR_W];
    assign wr_oor = |wr_req_addr[CL_ADDR_W-1:ADDR_W];
    always_ff @(posedge clk) begin
        if (!rst)
            err_range <= 1'b0;
        else if ((rd_push && rd_oor) || (wr_push && wr_oor))
            err_range <= 1'b1;
    end
`else
    logic unused_hi;
    assign unused_hi = ^{rd_req_addr[CL_ADDR_W-1:ADDR_W], wr_req_addr[CL_ADDR_W-1:ADDR_W]};
    assign rd_oor    = 1'b0;
    assign wr_oor    = 1'b0;
    assign err_range = 1'b0;
`endif

    // Entries store the stamp of the cycle after accept, so age RD_LATENCY-1 pops exactly RD_LATENCY cycles out.
    always_comb begin
        rd_full    = rq_occ == OW'(FIFO_DEPTH);
        rd_age     = stamp - rq_st[rq_rp];
        rd_pop     = rst && (rq_occ != '0) && (rd_age >= 8'(RD_LATENCY - 1));
        rd_push    = rst && rd_req_en && (!rd_full || rd_pop);
        rq_occ_nxt = rq_occ + OW'(rd_push) - OW'(rd_pop);
        wr_full    = wq_occ == OW'(FIFO_DEPTH);
        wr_age     = stamp - wq_st[wq_rp];
        wr_pop     = rst && (wq_occ != '0) && (wr_age >= 8'(WR_LATENCY - 1));
        wr_push    = rst && wr_req_en && (!wr_full || wr_pop);
        wq_occ_nxt = wq_occ + OW'(wr_push) - OW'(wr_pop);
    end

    // Payload storage and the line array need no reset.
    always_ff @(posedge clk) begin
        if (rd_push) begin
            rq_idx[rq_wp] <= rd_req_addr[ADDR_W-1:0];
            rq_md[rq_wp]  <= rd_req_mdata;
            rq_st[rq_wp]  <= stamp + 8'd1;
            rq_oor[rq_wp] <= rd_oor;
        end
        if (wr_push) begin
            wq_md[wq_wp] <= wr_req_mdata;
            wq_st[wq_wp] <= stamp + 8'd1;
            if (!wr_oor)
                mem[wr_req_addr[ADDR_W-1:0]] <= wr_req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stamp        <= '0;
            rq_wp        <= '0;
            rq_rp        <= '0;
            rq_occ       <= '0;
            wq_wp        <= '0;
            wq_rp        <= '0;
            wq_occ       <= '0;
            c0_alm_full  <= 1'b0;
            c1_alm_full  <= 1'b0;
            rd_rsp_valid <= 1'b0;
            rd_rsp_data  <= '0;
            rd_rsp_mdata <= '0;
            wr_rsp_valid <= 1'b0;
            wr_rsp_mdata <= '0;
            err_overflow <= 1'b0;
        end else begin
            stamp        <= stamp + 8'd1;
            rq_occ       <= rq_occ_nxt;
            wq_occ       <= wq_occ_nxt;
            c0_alm_full  <= (OW'(FIFO_DEPTH) - rq_occ_nxt) <= OW'(ALM_FULL_TH);
            c1_alm_full  <= (OW'(FIFO_DEPTH) - wq_occ_nxt) <= OW'(ALM_FULL_TH);
            rd_rsp_valid <= rd_pop;
            wr_rsp_valid <= wr_pop;
            if (rd_push)
                rq_wp <= rq_wp + PW'(1);
            if (wr_push)
                wq_wp <= wq_wp + PW'(1);
            if (rd_pop) begin
                rq_rp        <= rq_rp + PW'(1);
                rd_rsp_data  <= rq_oor[rq_rp] ? '0 : mem[rq_idx[rq_rp]];
                rd_rsp_mdata <= rq_md[rq_rp];
            end
            if (wr_pop) begin
                wq_rp        <= wq_rp + PW'(1);
                wr_rsp_mdata <= wq_md[wq_rp];
            end
            if ((rd_req_en && rd_full && !rd_pop) || (wr_req_en && wr_full && !wr_pop))
                err_overflow <= 1'b1;
        end
    end
endmodule
